// File: rtl/serial_sum_collector_pkg.sv
// Shared types and defaults for the serial sum collector (SIPO side of the serial adder).
package serial_sum_collector_pkg;

  // Collector FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Default geometry.
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  // Shift directions: where the first received bit of a frame ends up.
  localparam bit SHIFT_MSB_FIRST = 1'b1;  // first bit -> word[WIDTH-1]
  localparam bit SHIFT_LSB_FIRST = 1'b0;  // first bit -> word[0]

  // Bits needed to hold a frame bit count in 0..w.
  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in shift register. sr_next is the value the register takes on a
// shift, so the owner can capture a completed word on the same edge.
module sipo_shift_reg
  import serial_sum_collector_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = SHIFT_MSB_FIRST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clear,     // drop current contents; with shift_en, din becomes bit 0
  input  logic             din,
  output logic [WIDTH-1:0] sr_next
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] base;

  // Next shifted value, starting from an empty register when clearing.
  always_comb begin
    base = clear ? '0 : sr;
    if (MSB_FIRST) sr_next = {base[WIDTH-2:0], din};
    else           sr_next = {din, base[WIDTH-1:1]};
  end

  // Shift register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         sr <= '0;
    else if (shift_en) sr <= sr_next;
    else if (clear)    sr <= '0;
  end

endmodule

// File: rtl/serial_sum_collector.sv
// Frame-aligned serial-to-parallel collector with a one-word holding buffer,
// valid/ready output, framing/overrun error pulses and a delivered-word count.
module serial_sum_collector
  import serial_sum_collector_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = SHIFT_MSB_FIRST,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             frame_err,
  output logic             overrun_err,
  output logic [CNT_W-1:0] word_count
);

  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             shift_en, sr_clear, load_word, xfer;
  logic             frame_err_n, overrun_err_n;
  logic [WIDTH-1:0] sr_next;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .clear    (sr_clear),
    .din      (serial_in),
    .sr_next  (sr_next)
  );

  // Next-state and control decode.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    shift_en      = 1'b0;
    sr_clear      = 1'b0;
    load_word     = 1'b0;
    xfer          = 1'b0;
    frame_err_n   = 1'b0;
    overrun_err_n = 1'b0;
    unique case (state)
      IDLE: begin
        // Bits outside a frame are silently ignored.
        if (serial_valid && frame_start) begin
          shift_en = 1'b1;
          sr_clear = 1'b1;
          cnt_n    = CW'(1);
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (serial_valid) begin
          shift_en = 1'b1;
          if (frame_start) begin
            // Early restart: drop the partial frame, this bit is the new bit 0.
            sr_clear    = 1'b1;
            frame_err_n = 1'b1;
            cnt_n       = CW'(1);
          end else if (cnt == CNT_LAST) begin
            load_word = 1'b1;
            cnt_n     = '0;
            state_n   = HOLD;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      HOLD: begin
        if (word_ready) begin
          xfer = 1'b1;
          if (serial_valid && frame_start) begin
            // Back-to-back frame starts on the transfer cycle.
            shift_en = 1'b1;
            sr_clear = 1'b1;
            cnt_n    = CW'(1);
            state_n  = SHIFT;
          end else begin
            state_n = IDLE;
          end
        end else if (serial_valid) begin
          // No room for the bit while the word is held.
          overrun_err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, bit counter and error pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      frame_err   <= frame_err_n;
      overrun_err <= overrun_err_n;
    end
  end

  // Holding register and output handshake; word_out keeps the last word after transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (load_word) begin
      word_out   <= sr_next;
      word_valid <= 1'b1;
    end else if (xfer) begin
      word_valid <= 1'b0;
    end
  end

  // Delivered-word counter, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     word_count <= '0;
    else if (xfer) word_count <= word_count + CNT_W'(1);
  end

endmodule
